// File: rtl/compound_receiver_pkg.sv
// Shared types for the compound receiver: the sender-side transfer types
// (testbasic21_types) and the receiver's own FSM states and integer limits.
package testbasic21_types;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } Mode;

  typedef struct packed {
    Mode                mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;

  typedef enum logic [1:0] {
    SEC_IDLE,
    SEC_RUN,
    SEC_DONE
  } Sections;

endpackage

package compound_receiver_types;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_SEND = 1'b1
  } RxSections;

  localparam logic signed [31:0] INT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;

  // Overflow shows up as a mismatch between the sign bit and the carry-out.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? INT_MIN : INT_MAX;
    return s[31:0];
  endfunction

endpackage

// File: rtl/compound_receiver_if.sv
// Sender/consumer bus of the compound receiver; master drives data and
// handshakes toward the receiver, slave is the receiver itself.
interface compound_receiver_if;
  import testbasic21_types::*;

  CompoundType        b_in;
  logic               b_in_sync;
  logic               b_in_notify;
  CompoundType        m_in;
  logic signed [31:0] res_out;
  logic               res_out_sync;
  logic               res_out_notify;
  logic [7:0]         count_out;

  modport master (
    output b_in, b_in_sync, m_in, res_out_sync,
    input  b_in_notify, res_out, res_out_notify, count_out
  );

  modport slave (
    input  b_in, b_in_sync, m_in, res_out_sync,
    output b_in_notify, res_out, res_out_notify, count_out
  );
endinterface

// File: rtl/compound_receiver_acc.sv
// Accumulator with add/load/clear; COMPOUND_RECEIVER_SATURATE_EN selects
// saturating instead of wrapping additions.
module compound_receiver_acc
  import compound_receiver_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               add_en,
  input  logic               load_en,
  input  logic               clear_en,
  input  logic signed [31:0] x,
  input  logic signed [31:0] m_x,
  output logic signed [31:0] sum_m
);

  logic signed [31:0] acc;
  logic signed [31:0] acc_add;

`ifdef COMPOUND_RECEIVER_SATURATE_EN
  assign acc_add = sat_add(acc, x);
  assign sum_m   = sat_add(acc, m_x);
`else
  assign acc_add = acc + x;
  assign sum_m   = acc + m_x;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (load_en)  acc <= x;
    else if (add_en)   acc <= acc_add;
    else if (clear_en) acc <= '0;
  end

endmodule

// File: rtl/compound_receiver.sv
// Compound receiver: accumulates write transfers, answers read transfers with
// acc + m_in.x through a registered result handshake.
module compound_receiver
  import testbasic21_types::*;
  import compound_receiver_types::*;
(
  input logic                clk,
  input logic                rst,
  compound_receiver_if.slave bus
);

  RxSections          state;
  logic               b_notify_q;
  logic               r_notify_q;
  logic signed [31:0] res_q;
  logic [7:0]         count_q;
  logic signed [31:0] sum_m;
  logic               take_b;
  logic               is_write;
  logic               unused_m;

  assign take_b   = bus.b_in_sync && b_notify_q;
  assign is_write = (bus.b_in.mode == WRITE);
  assign unused_m = ^{bus.m_in.mode, bus.m_in.y};

  compound_receiver_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .add_en   (take_b && is_write && !bus.b_in.y),
    .load_en  (take_b && is_write &&  bus.b_in.y),
    .clear_en (take_b && !is_write && bus.b_in.y),
    .x        (bus.b_in.x),
    .m_x      (bus.m_in.x),
    .sum_m    (sum_m)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      b_notify_q <= 1'b1;
      r_notify_q <= 1'b0;
      res_q      <= '0;
      count_q    <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (take_b) begin
            if (is_write) begin
              count_q <= count_q + 8'd1;
            end else begin
              // sum_m uses the pre-clear acc; the clear lands on this same edge
              res_q      <= sum_m;
              b_notify_q <= 1'b0;
              r_notify_q <= 1'b1;
              state      <= RX_SEND;
            end
          end
        end
        RX_SEND: begin
          if (bus.res_out_sync && r_notify_q) begin
            r_notify_q <= 1'b0;
            b_notify_q <= 1'b1;
            state      <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign bus.b_in_notify    = b_notify_q;
  assign bus.res_out_notify = r_notify_q;
  assign bus.res_out        = res_q;
  assign bus.count_out      = count_q;

endmodule

// File: tb/tb_compound_receiver.sv
// Directed bench for compound_receiver: a vector table for the basic
// write/read flow plus hand-written stall, wrap, overflow and reset sequences.
module tb_compound_receiver;
  import testbasic21_types::*;
  import compound_receiver_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  compound_receiver_if bus();

  compound_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    Mode op;
    int  x;
    bit  y;
    int  mx;
    int  exp_res;
    int  exp_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Offer one b_in transfer and return one cycle after it is accepted.
  task automatic send_b(input Mode m, input int x, input bit y, input int mx);
    bit done;
    done = 1'b0;
    bus.b_in      = '{mode: m, x: x, y: y};
    bus.m_in      = '{mode: READ, x: mx, y: 1'b0};
    bus.b_in_sync = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.b_in_notify) done = 1'b1;
      step();
    end
    bus.b_in_sync = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_res(input string name, input int exp);
    check({name, "_valid"}, {31'd0, bus.res_out_notify}, 32'd1);
    check({name, "_busy"}, {31'd0, bus.b_in_notify}, 32'd0);
    check({name, "_res"}, bus.res_out, exp);
    bus.res_out_sync = 1'b1;
    step();
    bus.res_out_sync = 1'b0;
    check({name, "_done"}, {31'd0, bus.res_out_notify}, 32'd0);
    check({name, "_ready"}, {31'd0, bus.b_in_notify}, 32'd1);
  endtask

  function automatic int model_add(input int a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
`ifdef COMPOUND_RECEIVER_SATURATE_EN
    if (s > 64'sd2147483647)  return int'(32'h7FFF_FFFF);
    if (s < -64'sd2147483648) return int'(32'h8000_0000);
`endif
    return int'(s);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int model;
    int xv;

    tbl[0] = '{WRITE,   5, 1'b0,   0,   0, 1};
    tbl[1] = '{WRITE,   7, 1'b0,   0,   0, 2};
    tbl[2] = '{READ,    0, 1'b0, 100, 112, 2};
    tbl[3] = '{READ,    0, 1'b0,   0,  12, 2};
    tbl[4] = '{WRITE,   3, 1'b0,   0,   0, 3};
    tbl[5] = '{WRITE,   9, 1'b1,   0,   0, 4};
    tbl[6] = '{READ,    0, 1'b1,  50,  59, 4};
    tbl[7] = '{READ,    0, 1'b0,   0,   0, 4};
    tbl[8] = '{WRITE, -20, 1'b0,   0,   0, 5};
    tbl[9] = '{READ,    0, 1'b0,  -5, -25, 5};

    bus.b_in         = '0;
    bus.b_in_sync    = 1'b0;
    bus.m_in         = '0;
    bus.res_out_sync = 1'b0;
    rst              = 1'b1;
    #3;
    check("rst_b_notify", {31'd0, bus.b_in_notify}, 32'd1);
    check("rst_r_notify", {31'd0, bus.res_out_notify}, 32'd0);
    check("rst_res", bus.res_out, 32'd0);
    check("rst_count", {24'd0, bus.count_out}, 32'd0);
    step();
    rst = 1'b0;

    // Basic flow: writes back-to-back, reads with add / clear
    for (int i = 0; i < 10; i++) begin
      send_b(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].mx);
      if (tbl[i].op == WRITE) begin
        check($sformatf("vec%0d_ready", i), {31'd0, bus.b_in_notify}, 32'd1);
      end else begin
        read_res($sformatf("vec%0d", i), tbl[i].exp_res);
      end
      check($sformatf("vec%0d_count", i), {24'd0, bus.count_out}, tbl[i].exp_cnt);
    end

    // Consumer stall while the sender keeps offering a write
    do_reset();
    send_b(WRITE, 10, 1'b0, 0);
    send_b(READ, 0, 1'b0, 1);
    bus.b_in      = '{mode: WRITE, x: 100, y: 1'b0};
    bus.b_in_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_b_notify", i), {31'd0, bus.b_in_notify}, 32'd0);
      check($sformatf("stall%0d_valid", i), {31'd0, bus.res_out_notify}, 32'd1);
      check($sformatf("stall%0d_res", i), bus.res_out, 32'd11);
      check($sformatf("stall%0d_count", i), {24'd0, bus.count_out}, 32'd1);
      step();
    end
    bus.res_out_sync = 1'b1;
    step();
    bus.res_out_sync = 1'b0;
    check("stall_release_valid", {31'd0, bus.res_out_notify}, 32'd0);
    check("stall_release_count", {24'd0, bus.count_out}, 32'd1);
    step();
    bus.b_in_sync = 1'b0;
    check("stall_write_count", {24'd0, bus.count_out}, 32'd2);
    send_b(READ, 0, 1'b0, 0);
    read_res("stall_read", 110);
    bus.res_out_sync = 1'b1;
    step();
    bus.res_out_sync = 1'b0;
    check("idle_sync_valid", {31'd0, bus.res_out_notify}, 32'd0);
    check("idle_sync_res", bus.res_out, 32'd110);

    // 256 writes: counter wraps, acc follows the model sum
    do_reset();
    model = 0;
    for (int i = 0; i < 256; i++) begin
      xv    = (i * 37 + 1) * 16777213;
      model = model_add(model, xv);
      send_b(WRITE, xv, 1'b0, 0);
      if (i == 254) check("wrap_count_255", {24'd0, bus.count_out}, 32'd255);
    end
    check("wrap_count_0", {24'd0, bus.count_out}, 32'd0);
    send_b(READ, 0, 1'b0, 0);
    read_res("wrap_sum", model);

    // Overflow of the accumulator add
    do_reset();
    send_b(WRITE, int'(32'h7FFF_FFFF), 1'b0, 0);
    send_b(WRITE, 1, 1'b0, 0);
    send_b(READ, 0, 1'b0, 0);
`ifdef COMPOUND_RECEIVER_SATURATE_EN
    read_res("ovf", int'(32'h7FFF_FFFF));
`else
    read_res("ovf", int'(32'h8000_0000));
`endif

    // Reset in the middle of RX_SEND drops the result
    do_reset();
    send_b(WRITE, 4, 1'b0, 0);
    send_b(READ, 0, 1'b0, 6);
    check("pend_valid", {31'd0, bus.res_out_notify}, 32'd1);
    check("pend_res", bus.res_out, 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.res_out_notify}, 32'd0);
    check("mid_rst_res", bus.res_out, 32'd0);
    check("mid_rst_b_notify", {31'd0, bus.b_in_notify}, 32'd1);
    check("mid_rst_count", {24'd0, bus.count_out}, 32'd0);
    step();
    rst = 1'b0;
    bus.res_out_sync = 1'b1;
    step();
    bus.res_out_sync = 1'b0;
    check("post_rst_valid", {31'd0, bus.res_out_notify}, 32'd0);
    send_b(WRITE, 3, 1'b0, 0);
    check("post_rst_count", {24'd0, bus.count_out}, 32'd1);
    send_b(READ, 0, 1'b0, 0);
    read_res("post_rst", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
